// File: rtl/jtsdram_bank_test_if.sv
// Bank-port bus between the SDRAM bank exerciser and one bank port of the SDRAM controller.
//   addr : word address           (master -> slave)
//   rd   : read request           (master -> slave)
//   wr   : write request          (master -> slave)
//   din  : write data             (master -> slave)
//   ack  : request accepted       (slave -> master)
//   rdy  : read data valid / write completed (slave -> master)
//   dout : read data              (slave -> master)
interface jtsdram_bank_test_if #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 16
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] din;
  logic          ack;
  logic          rdy;
  logic [DW-1:0] dout;

  modport master (output addr, rd, wr, din, input ack, rdy, dout);
  modport slave  (input addr, rd, wr, din, output ack, rdy, dout);
endinterface

// File: rtl/jtsdram_bank_test.sv
// SDRAM bank exerciser. Sweeps addresses 0..last_addr of one bank. It can first write the
// pattern seed^addr and then read it back, or it can only read. Every read word is compared
// with the expected pattern.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle pulse, begins a test when idle/done
//   wr_en           : sampled at start, 1 = write pass then read pass
//   slow            : 1 = pseudo-random gaps between accesses, 0 = gaps wait for LVBL high
//   LVBL            : active-low vertical blank
//   seed, last_addr : pattern seed and final sweep address, sampled at start
//   bus             : bank-port bus (master side)
//   busy, done      : test in progress / test finished
//   bad, err_cnt    : sticky mismatch flag, saturating mismatch count
//   bad_addr        : address of the first mismatch
module jtsdram_bank_test #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 16,
  parameter int unsigned EW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                wr_en,
  input  logic                slow,
  input  logic                LVBL,
  input  logic [DW-1:0]       seed,
  input  logic [AW-1:0]       last_addr,
  jtsdram_bank_test_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                bad,
  output logic [EW-1:0]       err_cnt,
  output logic [AW-1:0]       bad_addr
);
  localparam int unsigned MW = (AW > DW) ? AW : DW;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StGap, StDone} state_e;

  state_e        state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] last_q;
  logic [DW-1:0] seed_q;
  logic          pass_wr;
  logic [15:0]   lfsr;
  logic [4:0]    gap;

  logic [DW-1:0] exp_cnt;
  logic          xfer_end;
  logic          last_hit;
  logic          mismatch;

  // Address is truncated or zero-extended to DW bits before the XOR.
  function automatic logic [DW-1:0] pattern(input logic [DW-1:0] s, input logic [AW-1:0] a);
    logic [MW-1:0] ext;
    ext = MW'(a);
    return s ^ ext[DW-1:0];
  endfunction

  always_comb begin
    exp_cnt  = pattern(seed_q, cnt);
    // A rdy that comes together with ack completes the access without a WAIT cycle.
    xfer_end = bus.rdy && ((state == StWait) || (state == StReq && bus.ack));
    last_hit = (cnt == last_q);
    mismatch = !pass_wr && (bus.dout != exp_cnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      cnt      <= '0;
      last_q   <= '0;
      seed_q   <= '0;
      pass_wr  <= 1'b0;
      lfsr     <= 16'hACE1;
      gap      <= '0;
      bus.addr <= '0;
      bus.rd   <= 1'b0;
      bus.wr   <= 1'b0;
      bus.din  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bad      <= 1'b0;
      err_cnt  <= '0;
      bad_addr <= '0;
    end else begin
      // x^16+x^14+x^13+x^11, free running
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

      unique case (state)
        StIdle, StDone: begin
          if (start) begin
            cnt      <= '0;
            last_q   <= last_addr;
            seed_q   <= seed;
            pass_wr  <= wr_en;
            bad      <= 1'b0;
            err_cnt  <= '0;
            bad_addr <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            bus.addr <= '0;
            bus.din  <= seed;  // pattern at address 0
            bus.rd   <= !wr_en;
            bus.wr   <= wr_en;
            state    <= StReq;
          end
        end
        StReq: begin
          if (bus.ack) begin
            bus.rd <= 1'b0;
            bus.wr <= 1'b0;
            state  <= StWait;
          end
        end
        StWait: begin
        end
        StGap: begin
          if (slow ? (gap <= 5'd1) : LVBL) begin
            bus.addr <= cnt;
            bus.din  <= exp_cnt;
            bus.rd   <= !pass_wr;
            bus.wr   <= pass_wr;
            state    <= StReq;
          end else if (slow) begin
            gap <= gap - 5'd1;
          end
        end
        default: state <= StIdle;
      endcase

      // Access completion; overrides the StReq -> StWait move when rdy came with ack.
      if (xfer_end) begin
        if (mismatch) begin
          bad <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + EW'(1);
          if (!bad) bad_addr <= cnt;
        end
        // Gap length 1..16 cycles, used only when slow is high during the gap.
        gap <= {1'b0, lfsr[3:0]} + 5'd1;
        if (last_hit) begin
          if (pass_wr) begin
            pass_wr <= 1'b0;
            cnt     <= '0;
            state   <= StGap;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= StDone;
          end
        end else begin
          cnt   <= cnt + AW'(1);
          state <= StGap;
        end
      end
    end
  end
endmodule

// File: tb/tb_jtsdram_bank_test.sv
// Testbench for jtsdram_bank_test. Scoreboard: each test pushes its expected request sequence
// and final result before start. A monitor compares accepted requests and the result at the
// rising edge of done.
module tb_jtsdram_bank_test;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam int EW = 2;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;

  typedef struct packed {
    logic          b;
    logic [EW-1:0] e;
    logic [AW-1:0] ba;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          wr_en = 1'b0;
  logic          slow = 1'b0;
  logic          LVBL = 1'b1;
  logic [DW-1:0] seed = '0;
  logic [AW-1:0] last_addr = '0;
  logic          busy;
  logic          done;
  logic          bad;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] bad_addr;

  jtsdram_bank_test_if #(.AW(AW), .DW(DW)) bus ();

  jtsdram_bank_test #(.AW(AW), .DW(DW), .EW(EW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .wr_en     (wr_en),
    .slow      (slow),
    .LVBL      (LVBL),
    .seed      (seed),
    .last_addr (last_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .bad       (bad),
    .err_cnt   (err_cnt),
    .bad_addr  (bad_addr)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  req_t        req_q[$];
  res_t        res_q[$];
  logic [DW-1:0] mem [16];
  logic [15:0] corrupt = '0;
  int          n_acc = 0;
  bit          rdy_hold = 1'b0;
  int          gap_mode = 0;  // 0 off, 1 expect exactly 1, 2 expect 1..16

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Controller and memory model; mixes ack/rdy latencies, including rdy in the ack cycle.
  initial begin
    int ack_dly;
    int rdy_dly;
    bit pending;
    logic [DW-1:0] rdata;
    ack_dly = 0;
    rdy_dly = 0;
    pending = 1'b0;
    rdata = '0;
    bus.ack = 1'b0;
    bus.rdy = 1'b0;
    bus.dout = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.ack = 1'b0;
      bus.rdy = 1'b0;
      if (rst) begin
        pending = 1'b0;
        ack_dly = 0;
      end else if (pending) begin
        if (rdy_dly == 0) begin
          bus.rdy = 1'b1;
          bus.dout = rdata;
          pending = 1'b0;
        end else begin
          rdy_dly--;
        end
      end else if (bus.rd || bus.wr) begin
        if (ack_dly > 0) begin
          ack_dly--;
        end else begin
          bus.ack = 1'b1;
          n_acc++;
          if (bus.wr) mem[bus.addr] = bus.din;
          rdata = mem[bus.addr] ^ (corrupt[bus.addr] ? 16'h0100 : 16'h0000);
          rdy_dly = rdy_hold ? 6 : (n_acc % 3);
          ack_dly = ((n_acc % 4) == 1) ? 1 : 0;
          if (rdy_dly == 0) begin
            bus.rdy = 1'b1;
            bus.dout = rdata;
          end else begin
            pending = 1'b1;
            rdy_dly--;
          end
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic prev_done;
    req_t r;
    res_t s;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ack && (bus.rd || bus.wr)) begin
        if (req_q.size() == 0) begin
          fail_now("unexpected_request");
        end else begin
          r = req_q.pop_front();
          check("req_kind", 32'(bus.wr), 32'(r.w));
          check("req_addr", 32'(bus.addr), 32'(r.a));
          if (r.w) check("wr_data", 32'(bus.din), 32'(r.d));
        end
      end
      if (done && !prev_done) begin
        if (res_q.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          s = res_q.pop_front();
          check("bad", 32'(bad), 32'(s.b));
          check("err_cnt", 32'(err_cnt), 32'(s.e));
          check("bad_addr", 32'(bad_addr), 32'(s.ba));
          check("busy_at_done", 32'(busy), 32'd0);
        end
      end
      prev_done = done;
    end
  end

  // Gap monitor: cycles strictly between a rdy and the next request assertion.
  initial begin
    int cyc;
    int rdy_cyc;
    int g;
    bit have_rdy;
    logic prev_req;
    cyc = 0;
    rdy_cyc = 0;
    have_rdy = 1'b0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!busy) have_rdy = 1'b0;
      if ((bus.rd || bus.wr) && !prev_req && have_rdy && gap_mode != 0) begin
        g = cyc - rdy_cyc - 1;
        if (gap_mode == 1) check("gap_fast", 32'(g), 32'd1);
        else check("gap_slow_in_1_16", 32'((g >= 1) && (g <= 16)), 32'd1);
      end
      if (bus.rdy) begin
        have_rdy = 1'b1;
        rdy_cyc = cyc;
      end
      prev_req = bus.rd || bus.wr;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_sweep(input logic we, input logic [DW-1:0] sd, input int n);
    for (int i = 0; i < n; i++) req_q.push_back({we, AW'(i), sd ^ DW'(i)});
  endtask

  task automatic push_res(input logic b, input logic [EW-1:0] e, input logic [AW-1:0] ba);
    res_q.push_back({b, e, ba});
  endtask

  task automatic run_test(input logic we, input logic [DW-1:0] sd, input logic [AW-1:0] la);
    @(negedge clk);
    wr_en = we;
    seed = sd;
    last_addr = la;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int i;
    i = 0;
    while (!done && i < budget) begin
      @(negedge clk);
      i++;
    end
    if (!done) fail_now(name);
    tick(3);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 32'(bus.addr), 32'd0);
    check({tag, "_rd"}, 32'(bus.rd), 32'd0);
    check({tag, "_wr"}, 32'(bus.wr), 32'd0);
    check({tag, "_din"}, 32'(bus.din), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bad"}, 32'(bad), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_bad_addr"}, 32'(bad_addr), 32'd0);
  endtask

  initial begin
    int a0;
    int i;
    int reqs;
    for (int k = 0; k < 16; k++) mem[k] = '0;

    tick(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    tick(2);

    // Read-only sweep, memory preloaded with the pattern
    for (int k = 0; k < 16; k++) mem[k] = 16'h5A5A ^ DW'(k);
    gap_mode = 1;
    push_sweep(1'b0, 16'h5A5A, 16);
    push_res(1'b0, 2'd0, 4'd0);
    run_test(1'b0, 16'h5A5A, 4'd15);
    wait_done("timeout_read_only", 1000);

    // Write then read
    for (int k = 0; k < 16; k++) mem[k] = '0;
    push_sweep(1'b1, 16'h1234, 16);
    push_sweep(1'b0, 16'h1234, 16);
    push_res(1'b0, 2'd0, 4'd0);
    run_test(1'b1, 16'h1234, 4'd15);
    wait_done("timeout_write_read", 2000);
    check("mem5_written", 32'(mem[5]), 32'h1231);

    // Two corrupted words
    corrupt = 16'h0208;
    push_sweep(1'b0, 16'h1234, 16);
    push_res(1'b1, 2'd2, 4'd3);
    run_test(1'b0, 16'h1234, 4'd15);
    wait_done("timeout_two_errors", 1000);

    // Six corrupted words, 2-bit counter saturates at 3
    corrupt = 16'h4896;
    push_sweep(1'b0, 16'h1234, 16);
    push_res(1'b1, 2'd3, 4'd1);
    run_test(1'b0, 16'h1234, 4'd15);
    wait_done("timeout_saturate", 1000);
    corrupt = '0;

    // Blanking-gated gap: LVBL low holds back the second request
    gap_mode = 0;
    LVBL = 1'b0;
    push_sweep(1'b0, 16'h1234, 4);
    push_res(1'b0, 2'd0, 4'd0);
    a0 = n_acc;
    run_test(1'b0, 16'h1234, 4'd3);
    i = 0;
    while (n_acc < a0 + 1 && i < 50) begin
      @(negedge clk);
      i++;
    end
    if (n_acc < a0 + 1) fail_now("timeout_first_access");
    tick(1);
    reqs = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.rd || bus.wr) reqs++;
    end
    check("lvbl_low_no_request", 32'(reqs), 32'd0);
    check("lvbl_low_acc_count", 32'(n_acc - a0), 32'd1);
    check("lvbl_low_busy", 32'(busy), 32'd1);
    LVBL = 1'b1;
    wait_done("timeout_lvbl", 1000);

    // Random gaps
    gap_mode = 2;
    slow = 1'b1;
    push_sweep(1'b0, 16'h1234, 16);
    push_res(1'b0, 2'd0, 4'd0);
    run_test(1'b0, 16'h1234, 4'd15);
    wait_done("timeout_slow", 3000);
    slow = 1'b0;

    // Reset during WAIT of the second write, then a clean restart
    gap_mode = 1;
    rdy_hold = 1'b1;
    push_sweep(1'b1, 16'h0F0F, 2);
    a0 = n_acc;
    run_test(1'b1, 16'h0F0F, 4'd15);
    i = 0;
    while (n_acc < a0 + 2 && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (n_acc < a0 + 2) fail_now("timeout_second_write");
    tick(2);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    tick(3);
    rst = 1'b0;
    rdy_hold = 1'b0;
    check("midreset_queue_drained", 32'(req_q.size()), 32'd0);
    push_sweep(1'b1, 16'h0F0F, 16);
    push_sweep(1'b0, 16'h0F0F, 16);
    push_res(1'b0, 2'd0, 4'd0);
    run_test(1'b1, 16'h0F0F, 4'd15);
    wait_done("timeout_restart", 2000);

    check("req_queue_empty", 32'(req_q.size()), 32'd0);
    check("res_queue_empty", 32'(res_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
